pipe_alu_rf: RTL and testbench

Parametrised 4-stage pipelined ALU with an internal register bank and a result memory, on a single clock.
- Stages: S1 operand fetch, S2 execute, S3 register writeback, S4 memory write.
- New versus the earlier two-phase pipeline: valid tracking per stage, operand forwarding (back-to-back dependent ops need no stalls), synchronous reset, debug read ports.
- Sits behind the instruction sequencer; feeds result-capture logic.

---
 rtl/pipe_alu_rf_pkg.sv | 32 +++
 rtl/pipe_alu_exec.sv | 72 +++++++
 rtl/pipe_alu_rf.sv | 157 +++++++++++++++
 tb/tb_pipe_alu_rf.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_alu_rf_pkg.sv
// Shared constants for pipe_alu_rf: opcode values, flag bit positions and
// default widths. Imported by pipe_alu_exec and pipe_alu_rf.
package pipe_alu_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned REG_AW_DEF = 4;
    localparam int unsigned MEM_AW_DEF = 8;
    localparam int unsigned FUNC_W_DEF = 4;

    localparam int unsigned OP_ADD = 0;
    localparam int unsigned OP_SUB = 1;
    localparam int unsigned OP_MUL = 2;
    localparam int unsigned OP_PA  = 3;
    localparam int unsigned OP_PB  = 4;
    localparam int unsigned OP_AND = 5;
    localparam int unsigned OP_OR  = 6;
    localparam int unsigned OP_XOR = 7;
    localparam int unsigned OP_NGA = 8;
    localparam int unsigned OP_NGB = 9;
    localparam int unsigned OP_SHR = 10;
    localparam int unsigned OP_SHL = 11;
    localparam int unsigned OP_ASR = 12;
    localparam int unsigned OP_NOT = 13;

    // flags[3:0] = {zero, neg, carry, ovf}
    localparam int unsigned FLAG_OVF   = 0;
    localparam int unsigned FLAG_CARRY = 1;
    localparam int unsigned FLAG_NEG   = 2;
    localparam int unsigned FLAG_ZERO  = 3;
    localparam int unsigned FLAG_W     = 4;

endpackage

// File: rtl/pipe_alu_exec.sv
// Purely combinational ALU used in the execute stage of pipe_alu_rf.
// Ports: a, b (operands), func (opcode) -> result; flags when
// PIPE_ALU_RF_FLAGS_EN is defined.
// Carry means carry-out for addition and borrow for subtraction/negation.
module pipe_alu_exec
    import pipe_alu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned FUNC_W = FUNC_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [FUNC_W-1:0] func,
`ifdef PIPE_ALU_RF_FLAGS_EN
    output logic [FLAG_W-1:0] flags,
`endif
    output logic [DATA_W-1:0] result
);

    // Opcode decode; reserved codes yield zero
    always_comb begin
        result = '0;
        case (func)
            FUNC_W'(OP_ADD): result = a + b;
            FUNC_W'(OP_SUB): result = a - b;
            FUNC_W'(OP_MUL): result = a * b;
            FUNC_W'(OP_PA):  result = a;
            FUNC_W'(OP_PB):  result = b;
            FUNC_W'(OP_AND): result = a & b;
            FUNC_W'(OP_OR):  result = a | b;
            FUNC_W'(OP_XOR): result = a ^ b;
            FUNC_W'(OP_NGA): result = '0 - a;
            FUNC_W'(OP_NGB): result = '0 - b;
            FUNC_W'(OP_SHR): result = {1'b0, a[DATA_W-1:1]};
            FUNC_W'(OP_SHL): result = {a[DATA_W-2:0], 1'b0};
            FUNC_W'(OP_ASR): result = {a[DATA_W-1], a[DATA_W-1:1]};
            FUNC_W'(OP_NOT): result = ~a;
            default:         result = '0;
        endcase
    end

`ifdef PIPE_ALU_RF_FLAGS_EN
    localparam int unsigned MSB = DATA_W - 1;

    // carry/ovf only for add, sub and the two negations
    always_comb begin
        flags            = '0;
        flags[FLAG_ZERO] = (result == '0);
        flags[FLAG_NEG]  = result[MSB];
        case (func)
            FUNC_W'(OP_ADD): begin
                flags[FLAG_CARRY] = (result < a);
                flags[FLAG_OVF]   = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
            end
            FUNC_W'(OP_SUB): begin
                flags[FLAG_CARRY] = (a < b);
                flags[FLAG_OVF]   = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
            end
            FUNC_W'(OP_NGA): begin
                flags[FLAG_CARRY] = (a != '0);
                flags[FLAG_OVF]   = a[MSB] && result[MSB];
            end
            FUNC_W'(OP_NGB): begin
                flags[FLAG_CARRY] = (b != '0);
                flags[FLAG_OVF]   = b[MSB] && result[MSB];
            end
            default: ;
        endcase
    end
`endif

endmodule

// File: rtl/pipe_alu_rf.sv
// Four-stage pipelined ALU with register bank and result memory.
// Stages: operand fetch (forwarded), execute, register writeback + result
// output, memory write. One op per cycle, no stalls.
// Ports: clk, rst (sync, active high); in_valid, rs1, rs2, rd, func, addr
// (instruction); out_valid, zout, zaddr (writeback result); rf_dbg_addr/data,
// mem_dbg_addr/data (combinational debug reads).
// Optional: PIPE_ALU_RF_FLAGS_EN adds flags[3:0] = {zero, neg, carry, ovf}.
module pipe_alu_rf
    import pipe_alu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF,
    parameter int unsigned MEM_AW = MEM_AW_DEF,
    parameter int unsigned FUNC_W = FUNC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic [FUNC_W-1:0] func,
    input  logic [MEM_AW-1:0] addr,
    output logic              out_valid,
    output logic [DATA_W-1:0] zout,
    output logic [MEM_AW-1:0] zaddr,
`ifdef PIPE_ALU_RF_FLAGS_EN
    output logic [FLAG_W-1:0] flags,
`endif
    input  logic [REG_AW-1:0] rf_dbg_addr,
    output logic [DATA_W-1:0] rf_dbg_data,
    input  logic [MEM_AW-1:0] mem_dbg_addr,
    output logic [DATA_W-1:0] mem_dbg_data
);

    localparam int unsigned NREG  = 2 ** REG_AW;
    localparam int unsigned NWORD = 2 ** MEM_AW;

    logic [DATA_W-1:0] regbank [NREG];
    logic [DATA_W-1:0] mem     [NWORD];

    // execute-stage registers (op whose ALU result is live this cycle)
    logic              ex_v;
    logic [DATA_W-1:0] ex_a, ex_b;
    logic [FUNC_W-1:0] ex_func;
    logic [REG_AW-1:0] ex_rd;
    logic [MEM_AW-1:0] ex_addr;

    // writeback-stage registers (result written to regbank on next edge)
    logic              wb_v;
    logic [DATA_W-1:0] wb_res;
    logic [REG_AW-1:0] wb_rd;
    logic [MEM_AW-1:0] wb_addr;

    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] opa, opb;

`ifdef PIPE_ALU_RF_FLAGS_EN
    logic [FLAG_W-1:0] alu_flags;
    logic [FLAG_W-1:0] wb_flags;
`endif

    pipe_alu_exec #(
        .DATA_W (DATA_W),
        .FUNC_W (FUNC_W)
    ) u_exec (
        .a      (ex_a),
        .b      (ex_b),
        .func   (ex_func),
`ifdef PIPE_ALU_RF_FLAGS_EN
        .flags  (alu_flags),
`endif
        .result (alu_res)
    );

    // Operand forwarding: youngest producer overrides older ones
    always_comb begin
        opa = regbank[rs1];
        if (wb_v && (wb_rd == rs1)) opa = wb_res;
        if (ex_v && (ex_rd == rs1)) opa = alu_res;
        opb = regbank[rs2];
        if (wb_v && (wb_rd == rs2)) opb = wb_res;
        if (ex_v && (ex_rd == rs2)) opb = alu_res;
    end

    // Operand fetch stage
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v    <= 1'b0;
            ex_a    <= '0;
            ex_b    <= '0;
            ex_func <= '0;
            ex_rd   <= '0;
            ex_addr <= '0;
        end else begin
            ex_v    <= in_valid;
            ex_a    <= opa;
            ex_b    <= opb;
            ex_func <= func;
            ex_rd   <= rd;
            ex_addr <= addr;
        end
    end

    // Execute stage result register
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_v    <= 1'b0;
            wb_res  <= '0;
            wb_rd   <= '0;
            wb_addr <= '0;
`ifdef PIPE_ALU_RF_FLAGS_EN
            wb_flags <= '0;
`endif
        end else begin
            wb_v    <= ex_v;
            wb_res  <= alu_res;
            wb_rd   <= ex_rd;
            wb_addr <= ex_addr;
`ifdef PIPE_ALU_RF_FLAGS_EN
            wb_flags <= alu_flags;
`endif
        end
    end

    // Register writeback and result output
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            zout      <= '0;
            zaddr     <= '0;
`ifdef PIPE_ALU_RF_FLAGS_EN
            flags     <= '0;
`endif
            for (int i = 0; i < NREG; i++) regbank[i] <= '0;
        end else begin
            out_valid <= wb_v;
            if (wb_v) begin
                zout           <= wb_res;
                zaddr          <= wb_addr;
`ifdef PIPE_ALU_RF_FLAGS_EN
                flags          <= wb_flags;
`endif
                regbank[wb_rd] <= wb_res;
            end
        end
    end

    // Memory write; blocked on the reset edge so no in-flight op lands
    always_ff @(posedge clk) begin
        if (!rst && out_valid) mem[zaddr] <= zout;
    end

    assign rf_dbg_data  = regbank[rf_dbg_addr];
    assign mem_dbg_data = mem[mem_dbg_addr];

endmodule

// File: tb/tb_pipe_alu_rf.sv
// Scoreboard bench for pipe_alu_rf: reference model computes each op from the
// architectural register state at issue time; a monitor checks each output.
module tb_pipe_alu_rf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  rs1 = '0, rs2 = '0, rd = '0, func = '0;
    logic [7:0]  addr = '0;
    logic        out_valid;
    logic [15:0] zout;
    logic [7:0]  zaddr;
    logic [3:0]  rf_dbg_addr = '0;
    logic [15:0] rf_dbg_data;
    logic [7:0]  mem_dbg_addr = '0;
    logic [15:0] mem_dbg_data;
`ifdef PIPE_ALU_RF_FLAGS_EN
    logic [3:0]  flags;
`endif

    pipe_alu_rf dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .func         (func),
        .addr         (addr),
        .out_valid    (out_valid),
        .zout         (zout),
        .zaddr        (zaddr),
`ifdef PIPE_ALU_RF_FLAGS_EN
        .flags        (flags),
`endif
        .rf_dbg_addr  (rf_dbg_addr),
        .rf_dbg_data  (rf_dbg_data),
        .mem_dbg_addr (mem_dbg_addr),
        .mem_dbg_data (mem_dbg_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        logic [15:0] res;
        logic [7:0]  addr;
        logic [3:0]  flg;
        int          due;
    } exp_t;

    exp_t        q[$];
    logic [15:0] m_rf [16];
    logic [15:0] m_mem [256];
    bit          m_memv [256];

    task automatic chk(input string name, input longint act, input longint exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference ALU in plain integer arithmetic
    function automatic logic [15:0] ref_alu(input int f, input longint a, input longint b,
                                            output logic [3:0] flg);
        longint sa, sb, full, sfull;
        bit c, v;
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        c = 0; v = 0; full = 0;
        case (f)
            0:  begin full = a + b; c = (full > 65535); sfull = sa + sb; v = (sfull > 32767 || sfull < -32768); end
            1:  begin full = a - b; c = (a < b);        sfull = sa - sb; v = (sfull > 32767 || sfull < -32768); end
            2:  full = a * b;
            3:  full = a;
            4:  full = b;
            5:  full = a & b;
            6:  full = a | b;
            7:  full = a ^ b;
            8:  begin full = -a; c = (a != 0); v = (sa == -32768); end
            9:  begin full = -b; c = (b != 0); v = (sb == -32768); end
            10: full = a >> 1;
            11: full = a << 1;
            12: full = sa >>> 1;
            13: full = ~a;
            default: full = 0;
        endcase
        full = full & 'hFFFF;
        flg = {full == 0, full >= 32768, c, v};
        return 16'(full);
    endfunction

    // Drive one instruction; when tracked, update the model and scoreboard
    task automatic issue_t(input int f, input int a1, input int a2, input int d,
                           input int ad, input bit tracked);
        exp_t e;
        logic [3:0] fl;
        in_valid = 1'b1;
        rs1 = 4'(a1); rs2 = 4'(a2); rd = 4'(d); func = 4'(f); addr = 8'(ad);
        if (tracked) begin
            e.res  = ref_alu(f, longint'(m_rf[a1]), longint'(m_rf[a2]), fl);
            e.flg  = fl;
            e.addr = 8'(ad);
            e.due  = cyc + 3;
            m_rf[d]    = e.res;
            m_mem[ad]  = e.res;
            m_memv[ad] = 1'b1;
            q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic issue(input int f, input int a1, input int a2, input int d, input int ad);
        issue_t(f, a1, a2, d, ad, 1'b1);
    endtask

    task automatic bubble();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    // Build a constant in rd from zeroed state using r15 as a "one" register
    task automatic load_const(input int d, input int val);
        bit started = 0;
        issue(7, 15, 15, 15, 255);
        issue(13, 15, 0, 15, 255);
        issue(8, 15, 0, 15, 255);
        issue(7, d, d, d, 255);
        for (int bi = 15; bi >= 0; bi--) begin
            if (started) issue(11, d, 0, d, 255);
            if (((val >> bi) & 1) != 0) begin
                issue(0, d, 15, d, 255);
                started = 1;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            bubble();
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
        bubble(); bubble();
    endtask

    task automatic chk_rf(input string name, input int r, input longint exp);
        rf_dbg_addr = 4'(r);
        #1;
        chk(name, rf_dbg_data, exp);
    endtask

    task automatic chk_mem(input string name, input int a, input longint exp);
        mem_dbg_addr = 8'(a);
        #1;
        chk(name, mem_dbg_data, exp);
    endtask

    // Monitor: every valid output must match the oldest expected entry
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("zout", zout, e.res);
                chk("zaddr", zaddr, e.addr);
                chk("latency", cyc, e.due);
`ifdef PIPE_ALU_RF_FLAGS_EN
                chk("flags", flags, e.flg);
`endif
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        for (int i = 0; i < 256; i++) begin m_mem[i] = '0; m_memv[i] = 1'b0; end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        for (int i = 0; i < 16; i++) chk_rf("reset_rf", i, 0);
        for (int i = 0; i < 3; i++) begin
            chk("reset_out_valid", out_valid, 0);
            chk("reset_zout", zout, 0);
            bubble();
        end

        // basic add with memory write
        load_const(1, 5);
        load_const(2, 3);
        issue(0, 1, 2, 3, 'h10);
        drain();
        chk_mem("mem_add", 'h10, 8);
        chk_rf("rf_add", 3, 8);

        // forwarding from execute, from writeback, and youngest-wins
        load_const(1, 7);
        issue(0, 1, 1, 4, 'h11);
        issue(1, 4, 1, 5, 'h12);
        drain();
        chk_rf("fwd_ex", 5, 7);
        issue(7, 5, 5, 5, 'h13);
        issue(0, 1, 1, 4, 'h11);
        bubble();
        issue(1, 4, 1, 5, 'h12);
        drain();
        chk_rf("fwd_wb", 5, 7);
        issue(0, 1, 1, 4, 'h11);
        issue(0, 4, 1, 4, 'h11);
        issue(1, 4, 1, 5, 'h12);
        drain();
        chk_rf("fwd_young", 5, 14);

        // width boundaries
        load_const(1, 'hFFFF);
        load_const(2, 1);
        issue(0, 1, 2, 7, 'h20);
        load_const(1, 'h0100);
        issue(2, 1, 1, 8, 'h21);
        load_const(1, 'h8000);
        issue(12, 1, 0, 9, 'h22);
        issue(10, 1, 0, 10, 'h23);
        issue(1, 1, 2, 11, 'h24);
        issue(0, 0, 0, 12, 'h25);
        drain();
        chk_rf("add_wrap", 7, 0);
        chk_rf("mul_trunc", 8, 0);
        chk_rf("asr", 9, 'hC000);
        chk_rf("shr", 10, 'h4000);
        chk_rf("sub_ovf", 11, 'h7FFF);
        chk_mem("mem_asr", 'h22, 'hC000);

        // reset discards in-flight ops
        issue_t(13, 9, 0, 3, 'h20, 1'b0);
        issue_t(13, 10, 0, 4, 'h21, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        repeat (4) bubble();
        for (int i = 0; i < 16; i++) chk_rf("rst_rf", i, 0);
        chk_mem("rst_mem_a", 'h20, m_mem['h20]);
        chk_mem("rst_mem_b", 'h21, m_mem['h21]);

        // seed registers, then randomized traffic
        load_const(1, 'h1234);
        load_const(2, 'hA5F0);
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) bubble();
            else issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 255)));
        end
        drain();
        for (int i = 0; i < 16; i++) chk_rf("rand_rf", i, m_rf[i]);
        for (int i = 0; i < 256; i++)
            if (m_memv[i]) chk_mem("rand_mem", i, m_mem[i]);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
